vga_sequencer: RTL
==================

VGA_SEQUENCER -- requirements
Module: vga_sequencer

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): H_ACTIVE 640 visible pixels; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk48 in 1: single clock, one pixel per cycle.
- rst_n in 1: reset, synchronous, active-low.
- line_ack in 1: renderer reports the requested line is ready.
- hsync out 1: horizontal sync, active-low.
- vsync out 1: vertical sync, active-low.
- de out 1: display enable, active-area pixel.
- pix_en out 1: de AND current line rendered OK; gates RGB.
- hpos out 11: current column.
- vpos out 10: current line.
- frame_strobe out 1: one-cycle pulse at the first cycle of each frame.
- frame_cnt out 8: animation frame counter.
- line_req out 1: request to render line line_num.
- line_num out 10: line being requested.
- underrun_cnt out 8: count of missed line deadlines.

Function
REQ-003 All outputs SHALL be registered; hsync/vsync/de/pix_en SHALL correspond to the registered hpos/vpos of the same cycle.
REQ-004 hpos SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) and wrap to 0; vpos SHALL increment on hpos wrap, over 0..V_TOTAL-1, and wrap to 0.
REQ-005 de SHALL be 1 iff hpos < H_ACTIVE and vpos < V_ACTIVE.
REQ-006 hsync SHALL be 0 iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC; vsync SHALL be 0 iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC.
REQ-007 frame_strobe SHALL be 1 exactly when hpos==0 and vpos==0; frame_cnt SHALL increment by 1 (mod 256) in that same cycle.
REQ-008 The handshake FSM SHALL have states IDLE, REQ and READY.
REQ-009 IDLE->REQ: in the cycle where hpos==H_ACTIVE and the next line (vpos+1, or 0 on wrap) is < V_ACTIVE, line_req SHALL rise and line_num SHALL be set to that next line.
REQ-010 REQ->READY: the first cycle line_ack==1 is sampled; line_req SHALL drop on the following cycle.
REQ-011 REQ->IDLE (deadline miss): if hpos==H_TOTAL-1 with no ack, then:
- line_req SHALL drop.
- underrun_cnt SHALL increment, saturating at 255.
- The next line SHALL be marked bad.
REQ-012 If line_ack and the deadline occur in the same cycle, ack SHALL win: no underrun, line OK.
REQ-013 On hpos wrap, READY SHALL return to IDLE, and the line_ok flag SHALL latch 1 (from READY) or 0 (from a miss).
REQ-014 pix_en SHALL equal de AND line_ok.
REQ-015 line_ack SHALL be ignored outside REQ.
REQ-016 line_req SHALL never be asserted during vertical blank lines.
REQ-017 Line 0 is requested during the last line of the frame (vpos==V_TOTAL-1).
REQ-018 The first frame after reset SHALL display line 0 blank (line_ok reset 0); this SHALL not count as an underrun.

Reset
REQ-019 While rst_n==0 at a clk48 edge, the following SHALL be cleared:
- hpos=0, vpos=0, frame_cnt=0, underrun_cnt=0.
- FSM=IDLE, line_req=0, line_num=0, line_ok=0.
- de=0, pix_en=0, frame_strobe=0.
- hsync=1, vsync=1.
REQ-020 Reset asserted mid-request SHALL abandon the request with no underrun increment.
REQ-021 The first cycle after reset release SHALL present hpos=0, vpos=0, frame_strobe=1.

Structure
REQ-022 The default timing constants and the FSM state enumeration SHALL reside in shared package vga_pkg.
REQ-023 The h/v counters plus sync/de decode SHALL be one sub-module, vga_timing.
REQ-024 The handshake FSM, line_ok and the counters SHALL reside in vga_sequencer.

Verification
REQ-025 Reset, then run 420000 cycles: exactly 1 frame_strobe per 420000 cycles; hsync low 96 cycles per 800-cycle line; vsync low 1600 cycles per frame; frame_cnt=1 after the first wrap.
REQ-026 line_ack tied to line_req (1-cycle response): line_req pulses 480 times per frame; line_num runs 1..479 then 0; underrun_cnt stays 0; pix_en==de after frame 0.
REQ-027 line_ack never asserted: underrun_cnt=255 after one frame (saturates); pix_en always 0.
REQ-028 Ack only at hpos==799 of line 9: no underrun; line 10 pix_en=1 for hpos 0..639.
REQ-029 Ack at hpos==0 of line 11, after the deadline: ignored; underrun_cnt +1; line 11 pix_en=0.
REQ-030 rst_n=0 for 1 cycle while line_req=1: all outputs return to reset values; underrun_cnt=0; line_req rises again at hpos=640 of vpos=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and the line-handshake state encoding.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_READY = 2'd2
    } line_state_e;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with registered sync, display-enable and frame-start decode.
// The *_nxt outputs expose next-cycle position so the sequencer can register aligned outputs.
module vga_timing import vga_pkg::*; #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] hpos,
    output logic [9:0]  vpos,
    output logic [10:0] hpos_nxt,
    output logic [9:0]  vpos_nxt,
    output logic        de_nxt,
    output logic        line_end,
    output logic        frame_end,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_strobe
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic        running_q, running_d;
    logic [10:0] hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;

    // The first edge out of reset presents (0,0) instead of advancing, so frame 0 starts cleanly.
    always_comb begin
        running_d = 1'b1;
        hpos_d    = '0;
        vpos_d    = '0;
        if (running_q) begin
            if (hpos_q == H_LAST) begin
                vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
            end else begin
                hpos_d = hpos_q + 11'd1;
                vpos_d = vpos_q;
            end
        end
        de_d    = (hpos_d < H_ACT) && (vpos_d < V_ACT);
        hsync_d = !((hpos_d >= HS_BEG) && (hpos_d < HS_END));
        vsync_d = !((vpos_d >= VS_BEG) && (vpos_d < VS_END));
        fs_d    = (hpos_d == 11'd0) && (vpos_d == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            hpos_q    <= '0;
            vpos_q    <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            running_q <= running_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            fs_q      <= fs_d;
        end
    end

    assign hpos         = hpos_q;
    assign vpos         = vpos_q;
    assign hpos_nxt     = hpos_d;
    assign vpos_nxt     = vpos_d;
    assign de_nxt       = de_d;
    assign line_end     = running_q && (hpos_q == H_LAST);
    assign frame_end    = line_end && (vpos_q == V_LAST);
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign de           = de_q;
    assign frame_strobe = fs_q;

endmodule

// File: rtl/vga_sequencer.sv
// VGA raster sequencer: requests each visible line from a renderer one line ahead,
// tracks whether it arrived before the deadline, and gates pixels on that result.
module vga_sequencer import vga_pkg::*; #(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        clk48,
    input  logic        rst_n,
    input  logic        line_ack,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        pix_en,
    output logic [10:0] hpos,
    output logic [9:0]  vpos,
    output logic        frame_strobe,
    output logic [7:0]  frame_cnt,
    output logic        line_req,
    output logic [9:0]  line_num,
    output logic [7:0]  underrun_cnt
);

    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    logic [10:0] hpos_nxt;
    logic [9:0]  vpos_nxt;
    logic        de_nxt, line_end, frame_end;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk          (clk48),
        .rst_n        (rst_n),
        .hpos         (hpos),
        .vpos         (vpos),
        .hpos_nxt     (hpos_nxt),
        .vpos_nxt     (vpos_nxt),
        .de_nxt       (de_nxt),
        .line_end     (line_end),
        .frame_end    (frame_end),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .frame_strobe (frame_strobe)
    );

    line_state_e state_q, state_d;
    logic [9:0]  req_line;
    logic        issue, miss;
    logic        line_req_q, line_req_d;
    logic [9:0]  line_num_q, line_num_d;
    logic [7:0]  underrun_q, underrun_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        line_ok_q, line_ok_d;
    logic        pix_en_q, pix_en_d;

    // Decisions use next-cycle position so line_req is high in the cycle hpos shows H_ACTIVE.
    assign req_line = (vpos_nxt == V_LAST) ? 10'd0 : vpos_nxt + 10'd1;
    assign issue    = (hpos_nxt == H_ACT) && (req_line < V_ACT);
    assign miss     = (state_q == ST_REQ) && line_end && !line_ack;

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack arriving on the deadline cycle still counts; either way the line closes at wrap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (issue) state_d = ST_REQ;
            ST_REQ: begin
                if (line_end)      state_d = ST_IDLE;
                else if (line_ack) state_d = ST_READY;
            end
            ST_READY: if (line_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        line_req_d  = (state_d == ST_REQ);
        line_num_d  = ((state_q == ST_IDLE) && issue) ? req_line : line_num_q;
        underrun_d  = (miss && (underrun_q != 8'hFF)) ? underrun_q + 8'd1 : underrun_q;
        frame_cnt_d = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;
        line_ok_d   = line_ok_q;
        if (line_end) begin
            line_ok_d = (state_q == ST_READY) || ((state_q == ST_REQ) && line_ack);
        end
        pix_en_d    = de_nxt && line_ok_d;
    end

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            line_req_q  <= 1'b0;
            line_num_q  <= '0;
            underrun_q  <= '0;
            frame_cnt_q <= '0;
            line_ok_q   <= 1'b0;
            pix_en_q    <= 1'b0;
        end else begin
            line_req_q  <= line_req_d;
            line_num_q  <= line_num_d;
            underrun_q  <= underrun_d;
            frame_cnt_q <= frame_cnt_d;
            line_ok_q   <= line_ok_d;
            pix_en_q    <= pix_en_d;
        end
    end

    assign pix_en       = pix_en_q;
    assign frame_cnt    = frame_cnt_q;
    assign line_req     = line_req_q;
    assign line_num     = line_num_q;
    assign underrun_cnt = underrun_q;

endmodule
